// File: rtl/mux_stream_n_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
// in_last/out_last exist only when MUX_STREAM_PKT_LOCK_EN is defined.
interface mux_stream_n_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = $clog2(N);

    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_ch;
`ifdef MUX_STREAM_PKT_LOCK_EN
    logic [N-1:0]         in_last;
    logic                 out_last;
`endif

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
`ifdef MUX_STREAM_PKT_LOCK_EN
        output in_last,
        input  out_last,
`endif
        input  in_ready, out_valid, out_data, out_ch
    );

    // Multiplexer side
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
`ifdef MUX_STREAM_PKT_LOCK_EN
        input  in_last,
        output out_last,
`endif
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_stream_n.sv
// N-channel registered valid/ready multiplexer, fixed-select or round-robin.
// Optional packet locking enabled by defining MUX_STREAM_PKT_LOCK_EN.
module mux_stream_n #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_stream_n_if.slave  bus
);
    localparam int SEL_W = $clog2(N);

    logic                 load_en_s;
    logic                 xfer_s;
    logic                 gnt_vld_s;
    logic [SEL_W-1:0]     gnt_ch_s;
    logic [WIDTH-1:0]     gnt_data_s;
    logic [N-1:0]         in_ready_s;
    logic [SEL_W-1:0]     ptr_r;
    logic                 out_valid_r;
    logic [WIDTH-1:0]     out_data_r;
    logic [SEL_W-1:0]     out_ch_r;

`ifdef MUX_STREAM_PKT_LOCK_EN
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    lock_state_e          state_r;
    lock_state_e          state_nxt_s;
    logic [SEL_W-1:0]     lock_ch_r;
    logic [SEL_W-1:0]     lock_ch_nxt_s;
    logic                 gnt_last_s;
    logic                 out_last_r;
`endif

    // Reset gating keeps in_ready low while rst_n is asserted
    assign load_en_s = rst_n && (!out_valid_r || bus.out_ready);
    assign xfer_s    = gnt_vld_s && load_en_s;

    // Grant selection: lock override, then fixed select or round-robin search
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_ch_s  = {SEL_W{1'b0}};
`ifdef MUX_STREAM_PKT_LOCK_EN
        if (state_r == LOCKED) begin
            gnt_vld_s = bus.in_valid[lock_ch_r];
            gnt_ch_s  = lock_ch_r;
        end else begin
`else
        begin
`endif
            if (bus.mode == 1'b0) begin
                // sel values >= N match no channel and therefore grant nothing
                for (int i = 0; i < N; i++) begin
                    if ((bus.sel == SEL_W'(i)) && bus.in_valid[i]) begin
                        gnt_vld_s = 1'b1;
                        gnt_ch_s  = SEL_W'(i);
                    end else begin
                        gnt_vld_s = gnt_vld_s;
                    end
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (!gnt_vld_s && bus.in_valid[SEL_W'((int'(ptr_r) + k) % N)]) begin
                        gnt_vld_s = 1'b1;
                        gnt_ch_s  = SEL_W'((int'(ptr_r) + k) % N);
                    end else begin
                        gnt_vld_s = gnt_vld_s;
                    end
                end
            end
        end
    end

    // Granted-channel payload and one-hot ready
    always_comb begin
        gnt_data_s = {WIDTH{1'b0}};
        in_ready_s = {N{1'b0}};
`ifdef MUX_STREAM_PKT_LOCK_EN
        gnt_last_s = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (gnt_ch_s == SEL_W'(i)) begin
                gnt_data_s    = bus.in_data[i*WIDTH +: WIDTH];
                in_ready_s[i] = xfer_s;
`ifdef MUX_STREAM_PKT_LOCK_EN
                gnt_last_s    = bus.in_last[i];
`endif
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            ptr_r       <= SEL_W'(N - 1);
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= gnt_data_s;
            out_ch_r    <= gnt_ch_s;
            ptr_r       <= gnt_ch_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef MUX_STREAM_PKT_LOCK_EN
    // Lock FSM next state: a non-last beat opens a packet, its last beat closes it
    always_comb begin
        state_nxt_s   = state_r;
        lock_ch_nxt_s = lock_ch_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && !gnt_last_s) begin
                    state_nxt_s   = LOCKED;
                    lock_ch_nxt_s = gnt_ch_s;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && gnt_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Lock FSM state, lock channel and registered last flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            lock_ch_r  <= {SEL_W{1'b0}};
            out_last_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            lock_ch_r <= lock_ch_nxt_s;
            if (xfer_s) begin
                out_last_r <= gnt_last_s;
            end
        end
    end

    assign bus.out_last = out_last_r;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;
endmodule

// File: doc/mux_stream_n.md
# mux_stream_n

Parametrised N-channel streaming multiplexer: the registered, handshaked successor to the 4:1 combinational mux. It selects one of N WIDTH-bit valid/ready input channels, either by an explicit select or by round-robin arbitration, and presents the chosen beat on a single registered output stream tagged with its source channel. It sits between multiple producers and a shared downstream consumer, such as a shared bus or serializer.

## Interface
- N, 4, number of input channels (2..16)
- WIDTH, 8, data width per channel (1..64)
- SEL_W, derived localparam = $clog2(N); not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel select, used when mode=0
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (one-hot or zero)
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  N  end-of-packet flag (present only with MUX_STREAM_PKT_LOCK_EN)
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream ready
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  source channel of out_data
- out_last  output  1  registered in_last of the beat (present only with MUX_STREAM_PKT_LOCK_EN)

## Operation
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Single-entry output register. load_en = !out_valid || out_ready.
- Grant, combinational:
  - mode=0: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel ≥ N is legal and grants nothing.
  - mode=1: search channels ptr+1, ptr+2, … modulo N; the first with in_valid=1 wins. Wrap from N-1 to 0.
- in_ready[g] = load_en for the granted channel g; all other in_ready bits are 0. in_ready never asserts without a grant.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - ptr <= g.
  - ptr updates in both modes, so a switch to round-robin continues fairly.
- Drain without a new load (out_valid && out_ready, no grant): out_valid <= 0; data and channel registers hold.
- Backpressure (out_valid && !out_ready): out_data, out_ch and out_last hold stable; all in_ready = 0.
- mode and sel are sampled every cycle. A change affects the next grant only and never the registered beat.
- Reset values: out_valid=0, out_data=0, out_ch=0, out_last=0, ptr=N-1 (channel 0 has first priority), lock state IDLE.
- Reset asserted mid-transfer clears the output register immediately. The in-flight beat is dropped.

## Timing
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready depends combinationally on out_ready, mode, sel, in_valid and the lock state. There are no combinational paths from in_data to any output.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… after reset.

## Configuration
- MUX_STREAM_PKT_LOCK_EN defined:
  - Adds in_last and out_last, plus a 2-state FSM (IDLE, LOCKED) with a lock_ch register.
  - IDLE -> LOCKED on a transfer with in_last=0; lock_ch <= g.
  - In LOCKED, the grant is forced to lock_ch regardless of mode and sel, and waits if in_valid[lock_ch]=0.
  - LOCKED -> IDLE on the transfer of the lock_ch beat with in_last=1.
  - A transfer with in_last=1 while IDLE stays in IDLE (single-beat packet).
  - out_last is the registered in_last of the beat.
- Macro undefined: no FSM, no in_last or out_last ports. Arbitration is per beat.

## Test plan
- Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0; the first grant after release is channel 0.
- Fixed select, N=4, WIDTH=8: mode=0, sel=2, in_data[2]=8'hA5, out_ready=1 -> out_data=8'hA5, out_ch=2 one cycle later; sel=3 with in_valid[3]=0 -> in_ready=0 and out_valid drops.
- Round-robin: all four channels valid, out_ready=1 -> out_ch sequence 0,1,2,3,0; with only channels 1 and 3 valid -> 1,3,1,3.
- Backpressure: hold out_ready=0 for 3 cycles with a beat pending -> out_data and out_ch stable, in_ready=0; releasing out_ready gives back-to-back beats with no gap.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 asynchronously (before the next clk edge); the next grant after release is channel 0.
- Packet lock (macro on): channel 1 sends 3 beats with in_last=0,0,1 while channel 0 is valid -> out_ch=1,1,1 then 0; out_last=1 only on the third beat.
